// File: rtl/bidirec_ctrl.sv
`default_nettype none
// ==========================================================================
// bidirec_ctrl: handshaked bidirectional pad controller with turnaround gap.
// Rev 1.0 | optional per-bit glitch filter macro: BIDIREC_CTRL_FILTER_EN
// ==========================================================================
module bidirec_ctrl #(
  parameter int SIZE        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD        = 1,
  parameter int TURNAROUND  = 1,
  parameter int FILTER_LEN  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_req,
  input  logic [SIZE-1:0] wr_data,
  input  logic [SIZE-1:0] wr_oe,
  output logic            wr_ack,
  output logic [SIZE-1:0] rd_data,
  output logic            rd_valid,
  output logic [SIZE-1:0] oe_out,
  inout  wire  [SIZE-1:0] bidir
);

`ifdef BIDIREC_CTRL_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  // Released cycles after a drive before read data is trusted again
  localparam int T       = TURNAROUND + SYNC_STAGES + (FILTER_ON ? FILTER_LEN : 0);
  localparam int CNT_MAX = (HOLD > T) ? HOLD : T;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(T - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;
  logic [SIZE-1:0]  drv_data, drv_oe;
  logic [SIZE-1:0]  sync_q [SYNC_STAGES];
  logic [SIZE-1:0]  sync_out;
  logic [SIZE-1:0]  rd_src;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
          cnt_nxt   = HOLD_LAST;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          state_nxt = TURN;
          cnt_nxt   = TURN_LAST;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      TURN: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = TURN;
        cnt_nxt   = TURN_LAST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TURN;
      cnt      <= TURN_LAST;
      drv_data <= '0;
      drv_oe   <= '0;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wr_ack   <= accept;
      rd_valid <= (state_nxt == IDLE);
      if (accept) begin
        drv_data <= wr_data;
        drv_oe   <= wr_oe;
      end
      if (state_nxt == IDLE) rd_data <= rd_src;
    end
  end

  // Synchroniser samples the pads in every state, including our own drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bidir;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef BIDIREC_CTRL_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);

  logic [SIZE-1:0] filt_q;
  logic [FCW-1:0]  fcnt [SIZE];

  // A bit flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int b = 0; b < SIZE; b++) fcnt[b] <= '0;
    end else begin
      for (int b = 0; b < SIZE; b++) begin
        if (sync_out[b] == filt_q[b]) begin
          fcnt[b] <= '0;
        end else if (fcnt[b] == FILT_LAST) begin
          filt_q[b] <= sync_out[b];
          fcnt[b]   <= '0;
        end else begin
          fcnt[b] <= fcnt[b] + 1'b1;
        end
      end
    end
  end

  assign rd_src = filt_q;
`else
  assign rd_src = sync_out;
`endif

  for (genvar i = 0; i < SIZE; i++) begin : g_pad
    assign bidir[i] = (state == DRIVE && drv_oe[i]) ? drv_data[i] : 1'bz;
  end

  assign oe_out = (state == DRIVE) ? drv_oe : '0;

endmodule
`default_nettype wire

// File: tb/tb_bidirec_ctrl.sv
`default_nettype none
// tb_bidirec_ctrl: directed, table-driven checks of handshake, pad drive and read path.
module tb_bidirec_ctrl;
  localparam int SYNC = 2;
`ifdef BIDIREC_CTRL_FILTER_EN
  localparam int FLEN = 3;
  localparam int T    = 1 + SYNC + FLEN;
`else
  localparam int FLEN = 0;
  localparam int T    = 1 + SYNC;
`endif
  localparam int LAT = SYNC + FLEN + 1;

  logic       clk = 1'b0;
  logic       rst_n, wr_req, wr_ack, rd_valid;
  logic [7:0] wr_data, wr_oe, rd_data, oe_out, ext_en, ext_val;
  wire  [7:0] bidir;

  logic       rst4_n, wr_req4, wr_ack4, rd_valid4;
  logic [7:0] wr_data4, wr_oe4, rd_data4, oe_out4, ext4_en, ext4_val;
  wire  [7:0] bidir4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign bidir[i]  = ext_en[i]  ? ext_val[i]  : 1'bz;
    assign bidir4[i] = ext4_en[i] ? ext4_val[i] : 1'bz;
  end

  bidirec_ctrl #(.SIZE(8), .SYNC_STAGES(SYNC), .HOLD(1), .TURNAROUND(1), .FILTER_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_data(wr_data), .wr_oe(wr_oe),
    .wr_ack(wr_ack), .rd_data(rd_data), .rd_valid(rd_valid), .oe_out(oe_out), .bidir(bidir)
  );

  bidirec_ctrl #(.SIZE(8), .SYNC_STAGES(SYNC), .HOLD(4), .TURNAROUND(1), .FILTER_LEN(3)) dut4 (
    .clk(clk), .rst_n(rst4_n), .wr_req(wr_req4), .wr_data(wr_data4), .wr_oe(wr_oe4),
    .wr_ack(wr_ack4), .rd_data(rd_data4), .rd_valid(rd_valid4), .oe_out(oe_out4), .bidir(bidir4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] oe;
    logic [7:0] ext;
    logic [7:0] exp_bus;
    logic [7:0] after;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] prev;
  int         first, second, extra;

  initial begin
    vecs[0] = '{8'h3C, 8'hFF, 8'h00, 8'h3C, 8'hC3};
    vecs[1] = '{8'h05, 8'h0F, 8'hA0, 8'hA5, 8'hA5};
    vecs[2] = '{8'hFF, 8'h00, 8'h5A, 8'h5A, 8'h0F};
    vecs[3] = '{8'h69, 8'hF0, 8'h03, 8'h63, 8'h96};

    rst_n  = 1'b0; wr_req  = 1'b0; wr_data  = '0; wr_oe  = '0; ext_en  = 8'hFF; ext_val  = 8'hA5;
    rst4_n = 1'b0; wr_req4 = 1'b0; wr_data4 = '0; wr_oe4 = '0; ext4_en = 8'h00; ext4_val = 8'h00;

    // Reset and release
    repeat (2) @(negedge clk);
    check("reset bus", bidir, 8'hA5);
    check("reset rd_valid", rd_valid, 0);
    check("reset wr_ack", wr_ack, 0);
    check("reset oe_out", oe_out, 0);
    check("reset rd_data", rd_data, 0);
    rst_n = 1'b1;
    for (int c = 1; c <= T; c++) begin
      tick();
      check("release rd_valid", rd_valid, (c == T));
    end
    check("release rd_data", rd_data, 8'hA5);

    // Read latency from a pad change
    ext_val = 8'h5A;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      check("read latency", rd_data, (c == LAT) ? 8'h5A : 8'hA5);
    end

`ifdef BIDIREC_CTRL_FILTER_EN
    for (int w = 1; w <= 2; w++) begin
      ext_val = 8'h5B;
      repeat (w) tick();
      ext_val = 8'h5A;
      for (int c = 0; c < LAT + 2; c++) begin
        tick();
        check("filter pulse", rd_data, 8'h5A);
      end
    end
`endif

    prev = 8'h5A;
    for (int v = 0; v < 4; v++) begin
      wr_req = 1'b1; wr_data = vecs[v].data; wr_oe = vecs[v].oe;
      ext_en = ~vecs[v].oe; ext_val = vecs[v].ext;
      tick();
      check("write ack", wr_ack, 1);
      check("drive oe_out", oe_out, vecs[v].oe);
      check("drive bus", bidir, vecs[v].exp_bus);
      check("drive rd_valid", rd_valid, 0);
      check("drive rd_data hold", rd_data, prev);
      wr_req = 1'b0;
      tick();
      check("ack one cycle", wr_ack, 0);
      check("released oe_out", oe_out, 0);
      ext_en = 8'hFF; ext_val = vecs[v].after;
      for (int c = 1; c <= T; c++) begin
        tick();
        check("turn rd_valid", rd_valid, (c == T));
      end
      check("return rd_data", rd_data, vecs[v].after);
      prev = vecs[v].after;
    end

    // Back-to-back requests: request held high across two writes
    ext_en = 8'h00;
    wr_req = 1'b1; wr_data = 8'h01; wr_oe = 8'hFF;
    first = -1; second = -1; extra = 0;
    for (int c = 0; c < 3 * (T + 2); c++) begin
      tick();
      if (first >= 0 && second < 0 && c == first + 1) check("b2b single drive", oe_out, 0);
      if (wr_ack) begin
        if (first < 0) begin
          first = c;
          check("b2b first value", bidir, 8'h01);
          wr_data = 8'h02;
        end else if (second < 0) begin
          second = c;
          check("b2b second value", bidir, 8'h02);
          wr_req = 1'b0;
        end else begin
          extra++;
        end
      end
    end
    wr_req = 1'b0;
    check("b2b ack spacing", second - first, T + 2);
    check("b2b extra acks", extra, 0);

    // Async reset in the middle of a 4-cycle drive
    rst4_n = 1'b1;
    repeat (T + 1) tick();
    check("hold4 idle", rd_valid4, 1);
    wr_req4 = 1'b1; wr_data4 = 8'h3C; wr_oe4 = 8'hFF;
    tick();
    check("hold4 ack", wr_ack4, 1);
    check("hold4 bus", bidir4, 8'h3C);
    wr_req4 = 1'b0;
    @(posedge clk); #2;
    check("hold4 still driving", oe_out4, 8'hFF);
    rst4_n = 1'b0; #1;
    check("async oe_out", oe_out4, 0);
    check("async wr_ack", wr_ack4, 0);
    check("async rd_valid", rd_valid4, 0);
    ext4_en = 8'hFF; ext4_val = 8'hC3; #1;
    check("async bus released", bidir4, 8'hC3);
    @(negedge clk);
    ext4_en = 8'h00;
    wr_req4 = 1'b1; wr_data4 = 8'h55;
    rst4_n = 1'b1;
    for (int c = 1; c <= T; c++) begin
      tick();
      check("restart turn rd_valid", rd_valid4, (c == T));
      check("restart no ack", wr_ack4, 0);
    end
    tick();
    check("restart ack", wr_ack4, 1);
    check("restart bus", bidir4, 8'h55);
    wr_req4 = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
